// File: rtl/hp_rd_req_scheduler.sv
// Huge-page read-request scheduler.
// Owns one host huge page at a time in strict round-robin order, slices it
// into chunk read requests for the TX engine, limits the number of chunks in
// flight to the tag space and requests the page-completed write once every
// chunk of the page has been requested and its completion data received.
module hp_rd_req_scheduler #(
   parameter int NUMB_HP         = 2,
   parameter int CHUNK_QW        = 64,
   parameter int MAX_OUTSTANDING = 16,
   parameter int QW_W            = 19
) (
   input  logic            trn_clk,
   input  logic            reset_n,
   input  logic            huge_page_status_0,
   input  logic            huge_page_status_1,
   input  logic [63:0]     huge_page_base_0,
   input  logic [63:0]     huge_page_base_1,
   input  logic [QW_W-1:0] huge_page_qw_0,
   input  logic [QW_W-1:0] huge_page_qw_1,
   output logic [63:0]     huge_page_addr,
   output logic [8:0]      qwords_to_rd,
   output logic            read_chunk,
   input  logic            read_chunk_ack,
   input  logic            chunk_cpl_done,
   output logic            send_huge_page_rd_completed,
   input  logic            send_huge_page_rd_completed_ack,
   output logic            huge_page_free_0,
   output logic            huge_page_free_1,
   output logic            hp_index
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      POST,
      DRAIN,
      NOTIFY
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [QW_W-1:0]   remaining;
   logic [QW_W-1:0]   remaining_after;
   logic [4:0]        outstanding;
   logic              sel_status;
   logic [63:0]       sel_base;
   logic [QW_W-1:0]   sel_qw;
   logic              below_cap;
   logic              issue_accept;
   logic              cpl_accept;

   // Length of the next chunk: a full chunk, or whatever is left of the page.
   function automatic logic [8:0] chunk_len(input logic [QW_W-1:0] rem);
      if (rem > QW_W'(CHUNK_QW)) begin
         chunk_len = 9'(CHUNK_QW);
      end else begin
         chunk_len = rem[8:0];
      end
   endfunction

   assign sel_status      = hp_index ? huge_page_status_1 : huge_page_status_0;
   assign sel_base        = hp_index ? huge_page_base_1   : huge_page_base_0;
   assign sel_qw          = hp_index ? huge_page_qw_1     : huge_page_qw_0;
   assign below_cap       = (outstanding < 5'(MAX_OUTSTANDING));
   assign remaining_after = remaining - QW_W'(qwords_to_rd);
   assign issue_accept    = read_chunk & read_chunk_ack;
   assign cpl_accept      = chunk_cpl_done & (outstanding != 5'd0);

   // State register.
   always_ff @(posedge trn_clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and the two request handshakes.
   always_comb begin
      state_next                  = state;
      read_chunk                  = 1'b0;
      send_huge_page_rd_completed = 1'b0;
      case (state)
         IDLE: begin
            if (sel_status) begin
               state_next = (sel_qw == '0) ? NOTIFY : REQ;
            end
         end
         REQ: begin
            if (remaining == '0) begin
               state_next = DRAIN;
            end else if (below_cap) begin
               read_chunk = 1'b1;
               if (read_chunk_ack) begin
                  state_next = POST;
               end
            end
         end
         POST: begin
            state_next = REQ;
         end
         DRAIN: begin
            if (outstanding == 5'd0) begin
               state_next = NOTIFY;
            end
         end
         NOTIFY: begin
            send_huge_page_rd_completed = 1'b1;
            if (send_huge_page_rd_completed_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Page walk: open the page, advance address/remaining after each accepted
   // chunk (length precomputed so it is valid as soon as REQ is entered),
   // release the page and move to the next one once page-done is accepted.
   always_ff @(posedge trn_clk) begin
      if (!reset_n) begin
         huge_page_addr   <= 64'd0;
         qwords_to_rd     <= 9'd0;
         remaining        <= '0;
         hp_index         <= 1'b0;
         huge_page_free_0 <= 1'b0;
         huge_page_free_1 <= 1'b0;
      end else begin
         huge_page_free_0 <= 1'b0;
         huge_page_free_1 <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_status) begin
                  huge_page_addr <= sel_base;
                  remaining      <= sel_qw;
                  qwords_to_rd   <= chunk_len(sel_qw);
               end
            end
            POST: begin
               huge_page_addr <= huge_page_addr + {52'd0, qwords_to_rd, 3'b000};
               remaining      <= remaining_after;
               qwords_to_rd   <= chunk_len(remaining_after);
            end
            NOTIFY: begin
               if (send_huge_page_rd_completed_ack) begin
                  huge_page_free_0 <= ~hp_index;
                  huge_page_free_1 <= hp_index;
                  hp_index         <= (hp_index == 1'(NUMB_HP - 1)) ? 1'b0 : ~hp_index;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Chunks in flight: up on an accepted request, down on a completion,
   // a stray completion with nothing in flight is dropped.
   always_ff @(posedge trn_clk) begin
      if (!reset_n) begin
         outstanding <= 5'd0;
      end else if (issue_accept && !cpl_accept) begin
         outstanding <= outstanding + 5'd1;
      end else if (!issue_accept && cpl_accept) begin
         outstanding <= outstanding - 5'd1;
      end
   end

endmodule
